// File: rtl/tile_matmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tile_matmul_seq
// Purpose  : Sequencer for tiled matrix multiplication between register-file
//            pages. Accepts one decoded operation word, splits an M x K x N
//            product into ARR x ARR output tiles (tn inner, tm outer), streams
//            K operand columns per tile, waits out the read + multiplier
//            latency, then issues one masked bulk tile write-back.
// Ports    : clk, reset (sync, active-high), enable (global freeze)
//            op_valid/op_ready/op_word/size_m/size_k/size_n : operation input
//            rd_*   : operand read strobe, bank/page/transpose, K and tile idx
//            mul_en/mul_clear : multiplier strobes (rd_en delayed by RD_LAT)
//            relu   : ReLU select held while busy
//            wr_*   : tile write-back strobe, address, tile idx, masks, acc
//            busy, done (pulse), err (pulse)
// Config   : TILE_MATMUL_SEQ_ACCUM_EN - when defined, op_word[25] drives
//            wr_acc on every write; otherwise wr_acc is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module tile_matmul_seq #(
  parameter int DW      = 32,
  parameter int ARR     = 8,
  parameter int DIM_W   = 9,
  parameter int BANK_W  = 2,
  parameter int PAGE_W  = 2,
  parameter int RD_LAT  = 1,
  parameter int MUL_LAT = 2*ARR-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DW-1:0]     op_word,
  input  logic [DIM_W-1:0]  size_m,
  input  logic [DIM_W-1:0]  size_k,
  input  logic [DIM_W-1:0]  size_n,
  output logic              rd_en,
  output logic [BANK_W-1:0] rd_x_bank,
  output logic [BANK_W-1:0] rd_w_bank,
  output logic [PAGE_W-1:0] rd_x_page,
  output logic [PAGE_W-1:0] rd_w_page,
  output logic              rd_x_trans,
  output logic              rd_w_trans,
  output logic [DIM_W-1:0]  rd_k,
  output logic [DIM_W-1:0]  rd_tm,
  output logic [DIM_W-1:0]  rd_tn,
  output logic              mul_en,
  output logic              mul_clear,
  output logic              relu,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [PAGE_W-1:0] wr_page,
  output logic [DIM_W-1:0]  wr_tm,
  output logic [DIM_W-1:0]  wr_tn,
  output logic              wr_acc,
  output logic [ARR-1:0]    wr_row_mask,
  output logic [ARR-1:0]    wr_col_mask,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DRAIN_N = RD_LAT + MUL_LAT;
  localparam int DRW     = $clog2(DRAIN_N + 1);
  localparam logic [DIM_W-1:0] ARR_D = DIM_W'(ARR);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    DRAIN  = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t state, state_next;

  // Operation word decode
  logic [3:0] opcode, x_addr, w_addr, d_addr;
  assign opcode = op_word[3:0];
  assign x_addr = op_word[7:4];
  assign w_addr = op_word[11:8];
  assign d_addr = op_word[15:12];

  logic accept, op_bad;
  assign op_ready = enable && (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign op_bad   = (opcode != 4'd1) || (size_m == '0) || (size_k == '0) ||
                    (size_n == '0) || (d_addr == x_addr) || (d_addr == w_addr);

  // Latched operation fields
  logic [BANK_W-1:0] x_bank_r, w_bank_r, d_bank_r;
  logic [PAGE_W-1:0] x_page_r, w_page_r, d_page_r;
  logic              x_trans_r, w_trans_r, relu_r;
  logic [DIM_W-1:0]  k_len, n_len;

  // Counters. rem_m / rem_n hold the rows/columns still to be covered from
  // the current tile onward, so tile-edge tests never form tm*ARR and cannot
  // overflow for dimensions near 2^DIM_W-1.
  logic [DIM_W-1:0]  k_cnt, tm, tn, rem_m, rem_n;
  logic [DRW-1:0]    drain_cnt;
  logic [RD_LAT-1:0] mul_pipe, clr_pipe;

  logic last_k, last_row, last_col, drain_last;
  assign last_k     = (k_cnt == k_len - DIM_W'(1));
  assign last_row   = (rem_m <= ARR_D);
  assign last_col   = (rem_n <= ARR_D);
  assign drain_last = (drain_cnt == DRW'(DRAIN_N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and strobes
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (opcode == 4'd0) state_next = DONE;
          else if (op_bad)    state_next = ERR;
          else                state_next = STREAM;
        end
      end
      STREAM: begin
        rd_en = 1'b1;
        if (last_k) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_next = WRITE;
      end
      WRITE: begin
        wr_en      = 1'b1;
        state_next = (last_row && last_col) ? DONE : STREAM;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A frozen sequencer holds its state and drives no strobes.
    if (!enable) begin
      state_next = state;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
    end
  end

  // Datapath: latches, counters and the read-to-multiply delay line
  always_ff @(posedge clk) begin
    if (reset) begin
      x_bank_r  <= '0;
      w_bank_r  <= '0;
      d_bank_r  <= '0;
      x_page_r  <= '0;
      w_page_r  <= '0;
      d_page_r  <= '0;
      x_trans_r <= 1'b0;
      w_trans_r <= 1'b0;
      relu_r    <= 1'b0;
      k_len     <= '0;
      n_len     <= '0;
      k_cnt     <= '0;
      tm        <= '0;
      tn        <= '0;
      rem_m     <= '0;
      rem_n     <= '0;
      drain_cnt <= '0;
      mul_pipe  <= '0;
      clr_pipe  <= '0;
    end else if (enable) begin
      mul_pipe[0] <= (state == STREAM);
      clr_pipe[0] <= (state == STREAM) && (k_cnt == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        mul_pipe[i] <= mul_pipe[i-1];
        clr_pipe[i] <= clr_pipe[i-1];
      end
      case (state)
        IDLE: begin
          if (accept) begin
            x_bank_r  <= x_addr[3 -: BANK_W];
            x_page_r  <= x_addr[PAGE_W-1:0];
            w_bank_r  <= w_addr[3 -: BANK_W];
            w_page_r  <= w_addr[PAGE_W-1:0];
            d_bank_r  <= d_addr[3 -: BANK_W];
            d_page_r  <= d_addr[PAGE_W-1:0];
            x_trans_r <= op_word[16];
            w_trans_r <= op_word[17];
            relu_r    <= op_word[18];
            k_len     <= size_k;
            n_len     <= size_n;
            rem_m     <= size_m;
            rem_n     <= size_n;
            k_cnt     <= '0;
            tm        <= '0;
            tn        <= '0;
            drain_cnt <= '0;
          end
        end
        STREAM: begin
          k_cnt     <= last_k ? '0 : k_cnt + DIM_W'(1);
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + DRW'(1);
        WRITE: begin
          if (!last_col) begin
            tn    <= tn + DIM_W'(1);
            rem_n <= rem_n - ARR_D;
          end else if (!last_row) begin
            tn    <= '0;
            rem_n <= n_len;
            tm    <= tm + DIM_W'(1);
            rem_m <= rem_m - ARR_D;
          end
        end
        default: ;
      endcase
    end
  end

  // Edge-tile masks: thermometer codes of min(ARR, remaining)
  always_comb begin
    wr_row_mask = '0;
    wr_col_mask = '0;
    for (int i = 0; i < ARR; i++) begin
      wr_row_mask[i] = (DIM_W'(i) < rem_m);
      wr_col_mask[i] = (DIM_W'(i) < rem_n);
    end
  end

  assign busy       = (state != IDLE);
  assign mul_en     = enable && mul_pipe[RD_LAT-1];
  assign mul_clear  = enable && clr_pipe[RD_LAT-1];
  assign relu       = relu_r && busy;
  assign rd_x_bank  = x_bank_r;
  assign rd_w_bank  = w_bank_r;
  assign rd_x_page  = x_page_r;
  assign rd_w_page  = w_page_r;
  assign rd_x_trans = x_trans_r;
  assign rd_w_trans = w_trans_r;
  assign rd_k       = k_cnt;
  assign rd_tm      = tm;
  assign rd_tn      = tn;
  assign wr_bank    = d_bank_r;
  assign wr_page    = d_page_r;
  assign wr_tm      = tm;
  assign wr_tn      = tn;

`ifdef TILE_MATMUL_SEQ_ACCUM_EN
  logic acc_r;
  always_ff @(posedge clk) begin
    if (reset)                 acc_r <= 1'b0;
    else if (enable && accept) acc_r <= op_word[25];
  end
  assign wr_acc = wr_en && acc_r;

  logic unused_op_bits;
  assign unused_op_bits = ^{op_word[DW-1:26], op_word[24:19]};
`else
  assign wr_acc = 1'b0;

  logic unused_op_bits;
  assign unused_op_bits = ^{op_word[DW-1:25], op_word[24:19]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_matmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_matmul_seq
// Purpose  : Self-checking bench for tile_matmul_seq. A table of directed
//            operations plus randomized ones are compared cycle by cycle
//            against a schedule model derived from the tiling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_matmul_seq;

  localparam int A = 8;

  logic        clk = 1'b0;
  logic        reset, enable, op_valid, op_ready;
  logic [31:0] op_word;
  logic [8:0]  size_m, size_k, size_n;
  logic        rd_en, rd_x_trans, rd_w_trans, mul_en, mul_clear, relu;
  logic [1:0]  rd_x_bank, rd_w_bank, rd_x_page, rd_w_page, wr_bank, wr_page;
  logic [8:0]  rd_k, rd_tm, rd_tn, wr_tm, wr_tn;
  logic        wr_en, wr_acc, busy, done, err;
  logic [7:0]  wr_row_mask, wr_col_mask;

  int tests = 0;
  int fails = 0;

  tile_matmul_seq dut (
    .clk(clk), .reset(reset), .enable(enable),
    .op_valid(op_valid), .op_ready(op_ready), .op_word(op_word),
    .size_m(size_m), .size_k(size_k), .size_n(size_n),
    .rd_en(rd_en), .rd_x_bank(rd_x_bank), .rd_w_bank(rd_w_bank),
    .rd_x_page(rd_x_page), .rd_w_page(rd_w_page),
    .rd_x_trans(rd_x_trans), .rd_w_trans(rd_w_trans),
    .rd_k(rd_k), .rd_tm(rd_tm), .rd_tn(rd_tn),
    .mul_en(mul_en), .mul_clear(mul_clear), .relu(relu),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_page(wr_page),
    .wr_tm(wr_tm), .wr_tn(wr_tn), .wr_acc(wr_acc),
    .wr_row_mask(wr_row_mask), .wr_col_mask(wr_col_mask),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int opc, input int x, input int w, input int d,
                                     input bit tx, input bit tw, input bit rl, input bit acc);
    return {6'b0, acc, 6'b0, rl, tw, tx, 4'(d), 4'(w), 4'(x), 4'(opc)};
  endfunction

  // Runs one operation and compares every cycle against the tiling schedule:
  // per tile of P = K+RD_LAT+MUL_LAT+1 = K+17 enabled cycles, reads occupy
  // offsets 0..K-1, multiplies 1..K, write-back at P-1; done follows the last
  // tile. Cycles with enable low do not advance the schedule.
  task automatic run_op(input string name, input logic [31:0] op,
                        input int M, input int K, input int N,
                        input int g0, input int gl, input bit noise,
                        output int end_cyc, output int first_wr, output int nwr,
                        output int mod_end, output int mod_nwr);
    int kind, end_pos, TMc, TNc, P, T, s, c, bad, i, j, etm, etn, rows, cols;
    bit en, in_t, e_rd, e_mul, e_clr, e_wr, e_done, e_err, e_busy, e_ready, eacc;
    logic [7:0] a8, e8, rm, cm;
    string msg;
    int opc;
    opc = int'(op[3:0]);
    TMc = (M + A - 1) / A;
    TNc = (N + A - 1) / A;
    P   = K + 17;
    T   = TMc * TNc * P;
    if (opc == 0) begin kind = 0; end_pos = 1; end
    else if (opc != 1 || M == 0 || K == 0 || N == 0 ||
             op[15:12] == op[7:4] || op[15:12] == op[11:8]) begin kind = 1; end_pos = 1; end
    else begin kind = 2; end_pos = T + 1; end
    mod_nwr = (kind == 2) ? TMc * TNc : 0;
`ifdef TILE_MATMUL_SEQ_ACCUM_EN
    eacc = op[25];
`else
    eacc = 1'b0;
`endif
    end_cyc = 0; first_wr = 0; nwr = 0; mod_end = 0; bad = 0; msg = "";
    @(negedge clk);
    enable = 1'b1; op_valid = 1'b1; op_word = op;
    size_m = 9'(M); size_k = 9'(K); size_n = 9'(N);
    @(posedge clk);
    s = 1; c = 1;
    while (s <= end_pos + 1) begin
      if (c > 20000) begin bad++; msg = "cycle budget expired"; break; end
      @(negedge clk);
      en = !(gl > 0 && c >= g0 && c < g0 + gl);
      enable   = en;
      op_valid = noise && (s <= end_pos);
      op_word  = $urandom;
      size_m   = 9'($urandom);
      size_k   = 9'($urandom);
      size_n   = 9'($urandom);
      #1;
      in_t = (kind == 2) && (s <= T);
      i = 0; j = 0; etm = 0; etn = 0;
      if (in_t) begin
        i = (s - 1) / P; j = (s - 1) % P;
        etm = i / TNc; etn = i % TNc;
      end
      e_rd    = en && in_t && (j < K);
      e_mul   = en && in_t && (j >= 1) && (j <= K);
      e_clr   = en && in_t && (j == 1);
      e_wr    = en && in_t && (j == P - 1);
      e_done  = en && (kind != 1) && (s == end_pos);
      e_err   = en && (kind == 1) && (s == end_pos);
      e_busy  = (s <= end_pos);
      e_ready = en && (s == end_pos + 1);
      a8 = {op_ready, busy, rd_en, mul_en, mul_clear, wr_en, done, err};
      e8 = {e_ready, e_busy, e_rd, e_mul, e_clr, e_wr, e_done, e_err};
      if (a8 !== e8) begin
        bad++;
        if (bad == 1) msg = $sformatf("cycle %0d strobes got %b exp %b", c, a8, e8);
      end
      if (in_t && j < K && rd_k !== 9'(j)) begin
        bad++;
        if (bad == 1) msg = $sformatf("cycle %0d rd_k got %0d exp %0d", c, rd_k, j);
      end
      if (e_rd && ({rd_tm, rd_tn, rd_x_bank, rd_x_page, rd_w_bank, rd_w_page,
                    rd_x_trans, rd_w_trans, relu} !==
                   {9'(etm), 9'(etn), op[7:6], op[5:4], op[11:10], op[9:8],
                    op[16], op[17], op[18]})) begin
        bad++;
        if (bad == 1) msg = $sformatf("cycle %0d read fields tm=%0d tn=%0d", c, rd_tm, rd_tn);
      end
      if (e_wr) begin
        rows = M - etm * A; if (rows > A) rows = A;
        cols = N - etn * A; if (cols > A) cols = A;
        rm = 8'((1 << rows) - 1);
        cm = 8'((1 << cols) - 1);
        if ({wr_tm, wr_tn, wr_bank, wr_page, wr_row_mask, wr_col_mask, wr_acc, relu} !==
            {9'(etm), 9'(etn), op[15:14], op[13:12], rm, cm, eacc, op[18]}) begin
          bad++;
          if (bad == 1)
            msg = $sformatf("cycle %0d write tm=%0d tn=%0d rows=%h cols=%h acc=%b exp tm=%0d tn=%0d rows=%h cols=%h acc=%b",
                            c, wr_tm, wr_tn, wr_row_mask, wr_col_mask, wr_acc, etm, etn, rm, cm, eacc);
        end
      end
      if ((done || err) && end_cyc == 0) end_cyc = c;
      if (wr_en) begin
        nwr++;
        if (first_wr == 0) first_wr = c;
      end
      if (e_done || e_err) mod_end = c;
      if (en) s++;
      c++;
    end
    op_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s trace: %0d bad cycles, first: %s", name, bad, msg);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    int m, k, n, g0, gl;
    int end_cyc, first_wr, nwr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int ec, fw, nw, me, mn, cnt, pos, cat, M, K, N, x, w, d, opc, g0, gl;
    logic [31:0] op;

    tbl[0]  = '{mk(1, 1, 5, 9, 0, 0, 0, 0),  8, 8,  8, 0, 0,   26, 25,   1};
    tbl[1]  = '{mk(1, 1, 2, 3, 1, 0, 1, 0), 16, 8, 16, 0, 0,  101, 25,   4};
    tbl[2]  = '{mk(1, 4, 6, 8, 0, 1, 0, 1), 12, 3, 20, 0, 0,  121, 20,   6};
    tbl[3]  = '{mk(5, 1, 2, 3, 0, 0, 0, 0),  8, 8,  8, 0, 0,    1,  0,   0};
    tbl[4]  = '{mk(1, 3, 2, 3, 0, 0, 0, 0),  8, 8,  8, 0, 0,    1,  0,   0};
    tbl[5]  = '{mk(1, 1, 2, 3, 0, 0, 0, 0),  8, 0,  8, 0, 0,    1,  0,   0};
    tbl[6]  = '{mk(0, 1, 2, 3, 0, 0, 0, 0),  8, 8,  8, 0, 0,    1,  0,   0};
    tbl[7]  = '{mk(1, 1, 7, 7, 0, 0, 0, 0),  8, 8,  8, 0, 0,    1,  0,   0};
    tbl[8]  = '{mk(1, 0, 4, 8, 1, 1, 1, 1),  1, 1,  1, 0, 0,   19, 18,   1};
    tbl[9]  = '{mk(1, 1, 5, 9, 0, 0, 0, 1),  8, 8,  8, 4, 5,   31, 30,   1};
    tbl[10] = '{mk(1, 2, 3, 15, 1, 1, 1, 1), 511, 1, 9, 0, 0, 2305, 18, 128};
    tbl[11] = '{mk(1, 1, 2, 3, 0, 0, 0, 0),  0, 4,  4, 0, 0,    1,  0,   0};

    reset = 1'b1; enable = 1'b0; op_valid = 1'b0; op_word = '0;
    size_m = '0; size_k = '0; size_n = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset op_ready (enable low)", {63'b0, op_ready}, 64'd0);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset strobes",
          {56'b0, rd_en, mul_en, mul_clear, wr_en, done, err, relu, wr_acc}, 64'd0);
    check("reset counters", {19'b0, rd_k, rd_tm, rd_tn, wr_tm, wr_tn}, 64'd0);
    check("reset addr/masks",
          {34'b0, rd_x_bank, rd_w_bank, rd_x_page, rd_w_page, rd_x_trans, rd_w_trans,
           wr_bank, wr_page, wr_row_mask, wr_col_mask}, 64'd0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    check("op_ready after enable", {63'b0, op_ready}, 64'd1);

    foreach (tbl[t]) begin
      run_op($sformatf("vec%0d", t), tbl[t].op, tbl[t].m, tbl[t].k, tbl[t].n,
             tbl[t].g0, tbl[t].gl, bit'(t % 2), ec, fw, nw, me, mn);
      check($sformatf("vec%0d end cycle", t), 64'(ec), 64'(tbl[t].end_cyc));
      check($sformatf("vec%0d first wr cycle", t), 64'(fw), 64'(tbl[t].first_wr));
      check($sformatf("vec%0d write count", t), 64'(nw), 64'(tbl[t].nwr));
    end

    // Reset mid-operation (STREAM and DRAIN): dropped, flushed, no write/done
    for (int r = 0; r < 2; r++) begin
      pos = (r == 0) ? 5 : 12;
      @(negedge clk);
      enable = 1'b1; op_valid = 1'b1; op_word = mk(1, 1, 5, 9, 0, 0, 0, 0);
      size_m = 9'd8; size_k = 9'd8; size_n = 9'd8;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      repeat (pos - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check($sformatf("reset@%0d idle", pos), {62'b0, busy, op_ready}, 64'd1);
      check($sformatf("reset@%0d mul_en flushed", pos), {63'b0, mul_en}, 64'd0);
      cnt = 0;
      repeat (40) begin
        @(negedge clk); #1;
        cnt += int'(wr_en) + int'(done) + int'(mul_en) + int'(rd_en);
      end
      check($sformatf("reset@%0d no strobes after", pos), 64'(cnt), 64'd0);
    end

    // Randomized operations against the schedule model
    for (int r = 0; r < 24; r++) begin
      cat = $urandom_range(0, 9);
      M = $urandom_range(1, 20); K = $urandom_range(1, 6); N = $urandom_range(1, 20);
      x = $urandom_range(0, 15); w = $urandom_range(0, 15);
      do d = $urandom_range(0, 15); while (d == x || d == w);
      opc = 1;
      if (cat == 0) opc = $urandom_range(2, 15);
      else if (cat == 1) begin
        case ($urandom_range(0, 2)) 0: M = 0; 1: K = 0; default: N = 0; endcase
      end else if (cat == 2) d = ($urandom_range(0, 1) != 0) ? x : w;
      else if (cat == 3) opc = 0;
      g0 = 0; gl = 0;
      if ($urandom_range(0, 1) != 0) begin
        g0 = $urandom_range(2, 30); gl = $urandom_range(1, 6);
      end
      op = mk(opc, x, w, d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      run_op($sformatf("rand%0d", r), op, M, K, N, g0, gl, 1'($urandom),
             ec, fw, nw, me, mn);
      check($sformatf("rand%0d end cycle", r), 64'(ec), 64'(me));
      check($sformatf("rand%0d write count", r), 64'(nw), 64'(mn));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
